// File: rtl/rom_programmer_pkg.sv
// Shared definitions for the PROM programmer.
// OP_* codes are the values presented on the operation output. rom_reader
// decodes the same codes.
// TIMER_WIDTH is the width of the phase down-counter.
package rom_programmer_pkg;

    localparam int TIMER_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_IDLE    = 4'd0,
        OP_SETUP   = 4'd1,
        OP_PULSE   = 4'd2,
        OP_RECOVER = 4'd3,
        OP_VERIFY  = 4'd4,
        OP_DONE    = 4'd5,
        OP_ERROR   = 4'd6
    } op_e;

endpackage

// File: rtl/prom_phase_timer.sv
// Loadable down-counter that times the programming phases.
// Ports:
//   clk, reset_n - system clock and async active-low reset
//   i_load       - load i_value this cycle
//   i_value      - value to load (phase length minus one)
//   o_expired    - count has reached zero
module prom_phase_timer
    import rom_programmer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [TIMER_WIDTH-1:0] i_value,
    output logic                   o_expired
);

    logic [TIMER_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/rom_programmer.sv
// Fuse PROM programmer. It steps an address counter, drives the address,
// data and CS lines, applies timed program pulses, reads each word back, and
// retries a bounded number of times.
// Ports:
//   clk, reset_n                         - clock, async active-low reset
//   increment_address/decrement_address  - address strobes, acted on in IDLE
//   start_program, data_line_in          - burn the given word at the current address
//   chip_data_in                         - readback from the PROM
//   operation                            - current state code (OP_*)
//   address_line, data_line_out, data_oe - socket address and data drive
//   chip_select_n, program_pulse         - PROM CS and programming enable
//   busy, done, verify_error             - status
//
// state   | meaning
// IDLE    | waiting; address strobes active
// SETUP   | CS low, data driven, before the first pulse
// PULSE   | programming voltage applied
// RECOVER | pulse off, data released, settling before readback
// VERIFY  | compare readback with the latched word
// DONE    | word verified (one cycle)
// ERROR   | retries exhausted (one cycle unless restarted)
module rom_programmer
    import rom_programmer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_INCREMENT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     increment_address,
    input  logic                     decrement_address,
    input  logic                     start_program,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    input  logic [DATA_WIDTH-1:0]    chip_data_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_line_out,
    output logic                     data_oe,
    output logic                     chip_select_n,
    output logic                     program_pulse,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_error
);

    op_e                      r_state;
    op_e                      w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [3:0]               r_retry;
    logic                     r_data_oe;
    logic                     r_cs_n;
    logic                     r_pulse;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_verify_error;

    logic                     w_tmr_load;
    logic [TIMER_WIDTH-1:0]   w_tmr_value;
    logic                     w_tmr_expired;
    logic                     w_accept;
    logic                     w_match;
    logic                     w_can_retry;

    prom_phase_timer u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    assign w_match     = (chip_data_in == r_data);
    assign w_can_retry = (r_retry < 4'(MAX_RETRIES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= OP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_accept    = 1'b0;
        case (r_state)
            OP_IDLE, OP_DONE, OP_ERROR: begin
                if (start_program) begin
                    w_accept    = 1'b1;
                    w_state_nxt = OP_SETUP;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_WIDTH'(SETUP_CYCLES - 1);
                end else begin
                    w_state_nxt = OP_IDLE;
                end
            end
            OP_SETUP: begin
                if (w_tmr_expired) begin
                    w_state_nxt = OP_PULSE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_WIDTH'(PULSE_CYCLES - 1);
                end
            end
            OP_PULSE: begin
                if (w_tmr_expired) begin
                    w_state_nxt = OP_RECOVER;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_WIDTH'(RECOVER_CYCLES - 1);
                end
            end
            OP_RECOVER: begin
                if (w_tmr_expired) begin
                    w_state_nxt = OP_VERIFY;
                end
            end
            OP_VERIFY: begin
                if (w_match) begin
                    w_state_nxt = OP_DONE;
                end else if (w_can_retry) begin
                    // Retries go straight back to PULSE; the lines are already set up.
                    w_state_nxt = OP_PULSE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_WIDTH'(PULSE_CYCLES - 1);
                end else begin
                    w_state_nxt = OP_ERROR;
                end
            end
            default: w_state_nxt = OP_IDLE;
        endcase
    end

    // The outputs are registered from the next state, so they always line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr         <= '0;
            r_data         <= '0;
            r_retry        <= '0;
            r_data_oe      <= 1'b0;
            r_cs_n         <= 1'b1;
            r_pulse        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_verify_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data         <= data_line_in;
                r_retry        <= '0;
                r_verify_error <= 1'b0;
            end else if (r_state == OP_VERIFY && !w_match && w_can_retry) begin
                r_retry <= r_retry + 1'b1;
            end

            if (r_state == OP_VERIFY && !w_match && !w_can_retry) begin
                r_verify_error <= 1'b1;
            end

            if (r_state == OP_IDLE && !start_program) begin
                if (increment_address && !decrement_address) begin
                    r_addr <= r_addr + 1'b1;
                end else if (decrement_address && !increment_address) begin
                    r_addr <= r_addr - 1'b1;
                end
            end else if (r_state == OP_VERIFY && w_match && AUTO_INCREMENT) begin
                r_addr <= r_addr + 1'b1;
            end

            r_done    <= (r_state == OP_VERIFY) && w_match;
            r_pulse   <= (w_state_nxt == OP_PULSE);
            r_data_oe <= (w_state_nxt == OP_SETUP) || (w_state_nxt == OP_PULSE);
            r_busy    <= (w_state_nxt == OP_SETUP) || (w_state_nxt == OP_PULSE) ||
                         (w_state_nxt == OP_RECOVER) || (w_state_nxt == OP_VERIFY);
            r_cs_n    <= !((w_state_nxt == OP_SETUP) || (w_state_nxt == OP_PULSE) ||
                           (w_state_nxt == OP_RECOVER) || (w_state_nxt == OP_VERIFY));
        end
    end

    assign operation     = r_state;
    assign address_line  = r_addr;
    assign data_line_out = r_data;
    assign data_oe       = r_data_oe;
    assign chip_select_n = r_cs_n;
    assign program_pulse = r_pulse;
    assign busy          = r_busy;
    assign done          = r_done;
    assign verify_error  = r_verify_error;

endmodule

// File: tb/tb_rom_programmer.sv
module tb_rom_programmer;

    logic       clk;
    logic       reset_n;
    logic       increment_address;
    logic       decrement_address;
    logic       start_program;
    logic [3:0] data_line_in;
    logic [3:0] chip_data_in;
    logic [3:0] operation;
    logic [7:0] address_line;
    logic [3:0] data_line_out;
    logic       data_oe;
    logic       chip_select_n;
    logic       program_pulse;
    logic       busy;
    logic       done;
    logic       verify_error;

    int n_pass  = 0;
    int n_total = 0;

    // Results of the most recent burn.
    int         b_pulses;
    int         b_hi;
    int         b_bad_run;
    int         b_side;
    int         b_rec;
    int         b_done_cnt;
    logic       b_ok;
    logic [3:0] b_end;
    logic       b_verr0;
    logic [3:0] b_op0;

    rom_programmer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .increment_address (increment_address),
        .decrement_address (decrement_address),
        .start_program     (start_program),
        .data_line_in      (data_line_in),
        .chip_data_in      (chip_data_in),
        .operation         (operation),
        .address_line      (address_line),
        .data_line_out     (data_line_out),
        .data_oe           (data_oe),
        .chip_select_n     (chip_select_n),
        .program_pulse     (program_pulse),
        .busy              (busy),
        .done              (done),
        .verify_error      (verify_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a burn and run it to DONE/ERROR. The PROM model returns the word
    // once `need` pulses have started; need == 0 means it never matches.
    task automatic burn(input logic [3:0] word, input int need);
        int   run;
        logic prev;
        b_pulses = 0; b_hi = 0; b_bad_run = 0; b_side = 0; b_rec = 0;
        b_done_cnt = 0; b_ok = 1'b0; b_end = 4'hF; run = 0; prev = 1'b0;
        chip_data_in  = ~word;
        data_line_in  = word;
        start_program = 1'b1;
        @(negedge clk);
        start_program = 1'b0;
        b_verr0 = verify_error;
        b_op0   = operation;
        for (int c = 0; c < 200; c++) begin
            if (program_pulse) begin
                b_hi++;
                run++;
                if (!prev) b_pulses++;
                if (!data_oe || chip_select_n || data_line_out !== word) b_side++;
            end else if (prev) begin
                if (run != 4) b_bad_run++;
                run = 0;
            end
            prev = program_pulse;
            if (operation == 4'd3) b_rec++;
            if (done) b_done_cnt++;
            chip_data_in = (need != 0 && b_pulses >= need) ? word : ~word;
            if (operation == 4'd5 || operation == 4'd6) begin
                b_end = operation;
                b_ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; increment_address = 1'b1; decrement_address = 1'b0;
        start_program = 1'b0; data_line_in = 4'h0; chip_data_in = 4'h0;
        repeat (3) @(negedge clk);
        n_total++; if (address_line !== 8'h00) $display("FAIL reset_addr got=%h exp=00", address_line); else n_pass++;
        n_total++; if (chip_select_n !== 1'b1) $display("FAIL reset_cs got=%b exp=1", chip_select_n); else n_pass++;
        n_total++; if (program_pulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", program_pulse); else n_pass++;
        n_total++; if (operation !== 4'd0) $display("FAIL reset_op got=%0d exp=0", operation); else n_pass++;
        n_total++;
        if ({busy, done, verify_error, data_oe, data_line_out} !== 8'h00)
            $display("FAIL reset_misc got=%b exp=00000000", {busy, done, verify_error, data_oe, data_line_out});
        else n_pass++;
        increment_address = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (address_line !== 8'h00) $display("FAIL reset_release_addr got=%h exp=00", address_line); else n_pass++;
    endtask

    task automatic test_addr();
        decrement_address = 1'b1; @(negedge clk); decrement_address = 1'b0;
        n_total++; if (address_line !== 8'hFF) $display("FAIL addr_dec_wrap got=%h exp=ff", address_line); else n_pass++;
        increment_address = 1'b1; @(negedge clk); increment_address = 1'b0;
        n_total++; if (address_line !== 8'h00) $display("FAIL addr_inc_wrap got=%h exp=00", address_line); else n_pass++;
        increment_address = 1'b1; decrement_address = 1'b1; @(negedge clk);
        increment_address = 1'b0; decrement_address = 1'b0;
        n_total++; if (address_line !== 8'h00) $display("FAIL addr_both got=%h exp=00", address_line); else n_pass++;
        increment_address = 1'b1; @(negedge clk);
        @(negedge clk); increment_address = 1'b0;
        n_total++; if (address_line !== 8'h02) $display("FAIL addr_inc2 got=%h exp=02", address_line); else n_pass++;
        decrement_address = 1'b1; @(negedge clk);
        @(negedge clk); decrement_address = 1'b0;
        n_total++; if (address_line !== 8'h00) $display("FAIL addr_dec2 got=%h exp=00", address_line); else n_pass++;
    endtask

    task automatic test_good_burn();
        burn(4'b1010, 1);
        n_total++; if (b_ok !== 1'b1 || b_end !== 4'd5) $display("FAIL good_end got=%0d exp=5", b_end); else n_pass++;
        n_total++; if (b_op0 !== 4'd1) $display("FAIL good_setup got=%0d exp=1", b_op0); else n_pass++;
        n_total++; if (b_pulses != 1 || b_hi != 4) $display("FAIL good_pulses got=%0d/%0d exp=1/4", b_pulses, b_hi); else n_pass++;
        n_total++; if (b_done_cnt != 1) $display("FAIL good_done got=%0d exp=1", b_done_cnt); else n_pass++;
        n_total++; if (b_side != 0) $display("FAIL good_side got=%0d exp=0", b_side); else n_pass++;
        n_total++; if (address_line !== 8'h01) $display("FAIL good_addr got=%h exp=01", address_line); else n_pass++;
        @(negedge clk);
        n_total++; if (operation !== 4'd0 || done !== 1'b0 || chip_select_n !== 1'b1)
            $display("FAIL good_idle got=%0d/%b/%b exp=0/0/1", operation, done, chip_select_n); else n_pass++;
    endtask

    task automatic test_retry();
        burn(4'b0101, 3);
        n_total++; if (b_ok !== 1'b1 || b_end !== 4'd5) $display("FAIL retry_end got=%0d exp=5", b_end); else n_pass++;
        n_total++; if (b_pulses != 3 || b_hi != 12) $display("FAIL retry_pulses got=%0d/%0d exp=3/12", b_pulses, b_hi); else n_pass++;
        n_total++; if (b_bad_run != 0) $display("FAIL retry_width got=%0d exp=0", b_bad_run); else n_pass++;
        n_total++; if (b_rec != 6) $display("FAIL retry_recover got=%0d exp=6", b_rec); else n_pass++;
        n_total++; if (verify_error !== 1'b0 || b_done_cnt != 1)
            $display("FAIL retry_status got=%b/%0d exp=0/1", verify_error, b_done_cnt); else n_pass++;
        n_total++; if (address_line !== 8'h02) $display("FAIL retry_addr got=%h exp=02", address_line); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_fail();
        burn(4'b0011, 0);
        n_total++; if (b_ok !== 1'b1 || b_end !== 4'd6) $display("FAIL fail_end got=%0d exp=6", b_end); else n_pass++;
        n_total++; if (b_pulses != 4 || b_hi != 16) $display("FAIL fail_pulses got=%0d/%0d exp=4/16", b_pulses, b_hi); else n_pass++;
        n_total++; if (verify_error !== 1'b1) $display("FAIL fail_verr got=%b exp=1", verify_error); else n_pass++;
        n_total++; if (address_line !== 8'h02 || b_done_cnt != 0)
            $display("FAIL fail_addr got=%h/%0d exp=02/0", address_line, b_done_cnt); else n_pass++;
        @(negedge clk);
        n_total++; if (verify_error !== 1'b1 || operation !== 4'd0)
            $display("FAIL fail_sticky got=%b/%0d exp=1/0", verify_error, operation); else n_pass++;
        burn(4'b0110, 1);
        n_total++; if (b_verr0 !== 1'b0 || b_op0 !== 4'd1)
            $display("FAIL fail_clear got=%b/%0d exp=0/1", b_verr0, b_op0); else n_pass++;
        n_total++; if (b_end !== 4'd5 || address_line !== 8'h03)
            $display("FAIL fail_reburn got=%0d/%h exp=5/03", b_end, address_line); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        data_line_in = 4'b1111; chip_data_in = 4'b0000;
        start_program = 1'b1; @(negedge clk);
        n_total++; if (operation !== 4'd1) $display("FAIL abort_setup got=%0d exp=1", operation); else n_pass++;
        increment_address = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_program = 1'b0; increment_address = 1'b0;
        n_total++; if (operation !== 4'd2 || program_pulse !== 1'b1)
            $display("FAIL abort_busy_start got=%0d/%b exp=2/1", operation, program_pulse); else n_pass++;
        n_total++; if (address_line !== 8'h03) $display("FAIL abort_busy_inc got=%h exp=03", address_line); else n_pass++;
        @(negedge clk);
        n_total++; if (program_pulse !== 1'b1) $display("FAIL abort_pulse2 got=%b exp=1", program_pulse); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (program_pulse !== 1'b0 || chip_select_n !== 1'b1 || operation !== 4'd0)
            $display("FAIL abort_async got=%b/%b/%0d exp=0/1/0", program_pulse, chip_select_n, operation); else n_pass++;
        increment_address = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (address_line !== 8'h00) $display("FAIL abort_addr got=%h exp=00", address_line); else n_pass++;
        increment_address = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (operation !== 4'd0 || busy !== 1'b0)
            $display("FAIL abort_release got=%0d/%b exp=0/0", operation, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addr();
        test_good_burn();
        test_retry();
        test_fail();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
